mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the P7 five-stage MIPS pipeline.
- Owns the architectural HI/LO registers and executes mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- Drives the busy/state pair that the hazard unit consumes to stall HI/LO instructions waiting in ID.
- Honours the exception/interrupt flush so that a cancelled instruction never starts an operation or writes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  EX-stage instruction is an MDU op; one-cycle qualifier.
- op  input  4  MDU operation code (encodings in mdu_pkg).
- a  input  32  rs operand, already forwarded.
- b  input  32  rt operand, already forwarded.
- flush  input  1  EX instruction is cancelled by an exception or interrupt this cycle.
- state  output  1  combinational: start & ~flush & op is a mult/div class op.
- busy  output  1  registered: a mult/div operation is in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- rd  output  32  combinational read data: hi when op==MFHI, lo when op==MFLO, else 0.

Behaviour:
- Reset (asynchronous, reset_n low):
  - busy=0, counter=0, hi=0, lo=0, pending result registers=0.
  - state and rd follow their combinational equations.
- Accept rule: an op is accepted in cycle T only when start=1, flush=0 and busy=0.
  - When busy=1, start is ignored. The stall unit prevents this case; the bench still checks that HI/LO stay undisturbed.
- MULT/MULTU, accepted at T:
  - 64-bit product computed at T, signed or unsigned per op, and latched into pending hi/lo.
  - counter loads MULT_CYCLES; busy=1 in cycles T+1..T+MULT_CYCLES.
  - HI/LO are written on the edge that ends cycle T+MULT_CYCLES, so the new values are visible with busy=0 in T+MULT_CYCLES+1.
- DIV/DIVU:
  - Same timing as MULT, using DIV_CYCLES.
  - Result: LO=quotient, HI=remainder, signed or unsigned per op.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - b==0: the operation still occupies DIV_CYCLES, HI/LO are left unchanged.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0, no trap.
- MTHI/MTLO: write a into HI/LO on the edge ending T. No busy cycle; state stays 0.
- MFHI/MFLO:
  - No state change.
  - rd returns the current architectural HI/LO; a pending result is never visible.
- Counter: 4-bit down-counter.
  - Decrements while busy.
  - busy deasserts and HI/LO commit when the counter reaches 1.
  - No wrap-around is possible.
- flush with start in the same cycle: nothing is accepted and state=0.
- flush while busy: the in-flight operation completes and commits (MIPS semantics, since the issuing instruction already retired past EX).
- Reset mid-operation: the operation is aborted, busy=0 and HI/LO=0 immediately.
- Undefined op with start=1: treated as a no-op.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds MADD, MADDU, MSUB and MSUBU opcodes.
  - {HI,LO} +/- the product (signed or unsigned) is computed at accept time, using the HI/LO values at T.
  - Timing is MULT_CYCLES; state asserts for these ops.
- Undefined: these encodings are undefined ops and behave as no-ops.

Decomposition:
- mdu_pkg holds:
  - op encodings: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, plus MADD, MADDU, MSUB, MSUBU;
  - default cycle constants;
  - an is_muldiv classification function, shared with the hazard unit's decoder.
- One sub-module, mdu_arith: purely combinational product/quotient/remainder generation including the zero-divisor and overflow rules.
- mdu_unit keeps the counter, busy flag, pending registers and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFE(-2), b=3 at T:
  - state=1 at T; busy=1 for T+1..T+5.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA first visible at T+6.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV a=-7, b=2:
  - busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU a=7, b=0: HI/LO unchanged after 10 busy cycles.
- MTLO a=0x12345678 at T → lo=0x12345678 at T+1, busy never asserts. MFLO at T+1 → rd=0x12345678.
- start=1, flush=1, op=MULT → state=0, busy stays 0, HI/LO unchanged.
  - A second case: flush during busy; the result still commits on schedule.
- reset_n pulsed low at busy cycle 3 of DIV → busy=0 and hi=lo=0 immediately. A new MULT after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, result payload and the mult/div classifier used by the hazard unit.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9,
    OP_MSUB  = 4'd10,
    OP_MSUBU = 4'd11
  } mdu_op_e;

  // Result of a mult/div class op; wr=0 means HI/LO must be left alone.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              wr;
  } mdu_res_t;

  // Ops that occupy the unit for a multi-cycle busy window.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops that use the divide latency instead of the multiply latency.
  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational product / quotient / remainder generation for the MDU.
// Handles divide-by-zero (no write) and signed 0x80000000 / -1 without a trap.
// With MDU_MADD_EN defined, also accumulates the product into {HI,LO}.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
`ifdef MDU_MADD_EN
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
`endif
  output mdu_res_t          res_c
);

  logic              sgn;
  logic [63:0]       ext_a;
  logic [63:0]       ext_b;
  logic [63:0]       prod;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] div_b;
  logic              b_nz;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  // Signed flavours of each op class.
  always_comb begin
    sgn = 1'b0;
    case (op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: sgn = 1'b1;
      default:                           sgn = 1'b0;
    endcase
  end

  // Full 64-bit product; sign/zero extension makes one multiplier serve both.
  assign ext_a = sgn ? {{32{a[31]}}, a} : {32'd0, a};
  assign ext_b = sgn ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = ext_a * ext_b;

  // Magnitude divide, then restore signs: quotient toward zero, remainder follows dividend.
  // The -2^31 / -1 case falls out naturally as 0x80000000 rem 0.
  assign mag_a = (sgn && a[31]) ? (~a + 32'd1) : a;
  assign mag_b = (sgn && b[31]) ? (~b + 32'd1) : b;
  assign b_nz  = (b != 32'd0);
  assign div_b = b_nz ? mag_b : 32'd1;
  assign q_mag = mag_a / div_b;
  assign r_mag = mag_a % div_b;
  assign quo   = (sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = (sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;

  // Select the result payload for the current op.
  always_comb begin
    res_c = '0;
    case (op)
      OP_MULT, OP_MULTU: begin
        res_c.hi = prod[63:32];
        res_c.lo = prod[31:0];
        res_c.wr = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_c.hi = rem;
        res_c.lo = quo;
        res_c.wr = b_nz;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        {res_c.hi, res_c.lo} = {acc_hi, acc_lo} + prod;
        res_c.wr = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        {res_c.hi, res_c.lo} = {acc_hi, acc_lo} - prod;
        res_c.wr = 1'b1;
      end
`endif
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, the busy window and the
// pending result that commits when the latency counter expires.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              state,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd
);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  mdu_res_t          pend_q, pend_d;
  mdu_res_t          arith_res_c;
  logic              accept_c;

  mdu_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
`ifdef MDU_MADD_EN
    .acc_hi (hi_q),
    .acc_lo (lo_q),
`endif
    .res_c  (arith_res_c)
  );

  // An op is taken only when qualified, not cancelled and the unit is idle.
  assign accept_c = start && !flush && !busy_q;

  // Next-state: run the busy window down, or accept a new op.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (pend_q.wr) begin
          hi_d = pend_q.hi;
          lo_d = pend_q.lo;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (accept_c) begin
      if (is_muldiv(op)) begin
        busy_d = 1'b1;
        cnt_d  = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pend_d = arith_res_c;
      end else if (op == OP_MTHI) begin
        hi_d = a;
      end else if (op == OP_MTLO) begin
        lo_d = a;
      end
    end
  end

  // State registers; reset aborts any in-flight op and clears HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign state = start && !flush && is_muldiv(op);
  assign rd    = (op == OP_MFHI) ? hi_q :
                 (op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus random ops checked
// against a behavioural model of HI/LO and the busy window.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        state;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_wr;
  int          m_left;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .state(state), .busy(busy), .hi(hi), .lo(lo), .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_md(input logic [3:0] o);
    if (o <= 4'd3) return 1'b1;
`ifdef MDU_MADD_EN
    if (o >= 4'd8 && o <= 4'd11) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] mul_ref(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Apply one accepted-or-not op to the model at a rising edge.
  task automatic model_step(input logic st, input logic [3:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic fl);
    logic [63:0] pr;
    int sx, sy;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (st && !fl) begin
      case (o)
        4'd0, 4'd1: begin
          pr = mul_ref(o == 4'd0, x, y);
          {p_hi, p_lo} = pr; p_wr = 1'b1; m_left = MC;
        end
        4'd2: begin
          m_left = DC; p_wr = (y != 0);
          if (y != 0) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
              p_lo = x; p_hi = 32'd0;
            end else begin
              sx = $signed(x); sy = $signed(y);
              p_lo = 32'(sx / sy); p_hi = 32'(sx % sy);
            end
          end
        end
        4'd3: begin
          m_left = DC; p_wr = (y != 0);
          if (y != 0) begin p_lo = x / y; p_hi = x % y; end
        end
        4'd4: m_hi = x;
        4'd5: m_lo = x;
`ifdef MDU_MADD_EN
        4'd8, 4'd9: begin
          pr = mul_ref(o == 4'd8, x, y);
          {p_hi, p_lo} = {m_hi, m_lo} + pr; p_wr = 1'b1; m_left = MC;
        end
        4'd10, 4'd11: begin
          pr = mul_ref(o == 4'd10, x, y);
          {p_hi, p_lo} = {m_hi, m_lo} - pr; p_wr = 1'b1; m_left = MC;
        end
`endif
        default: ;
      endcase
    end
  endtask

  // One clock cycle starting just after a falling edge.
  task automatic cycle(input logic st, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic fl);
    logic [31:0] exp_rd;
    start = st; op = o; a = x; b = y; flush = fl;
    #1;
    exp_rd = (o == 4'd6) ? m_hi : (o == 4'd7) ? m_lo : 32'd0;
    chk("state", 32'(state), 32'(st && !fl && is_md(o)));
    chk("rd", rd, exp_rd);
    @(posedge clk);
    model_step(st, o, x, y, fl);
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, (i % 2 == 0) ? 4'd6 : 4'd7, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0; m_left = 0;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 4'd0; a = 0; b = 0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // MULT -2 * 3
    cycle(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    idle(4);
    chk("mult_busy_last", 32'(busy), 32'd1);
    idle(1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    // MULTU max * max
    cycle(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    idle(5);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    // DIV -7 / 2
    cycle(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    idle(9);
    chk("div_busy_last", 32'(busy), 32'd1);
    idle(1);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // DIVU by zero leaves HI/LO
    cycle(1'b1, OP_DIVU, 32'd7, 32'd0, 1'b0);
    idle(10);
    chk("divz_lo", lo, 32'hFFFFFFFD);
    chk("divz_hi", hi, 32'hFFFFFFFF);

    // MTLO then MFLO
    cycle(1'b1, OP_MTLO, 32'h12345678, 32'd0, 1'b0);
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_lo", lo, 32'h12345678);
    op = OP_MFLO; #1;
    chk("mflo_rd", rd, 32'h12345678);
    cycle(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);

    // start with flush is dropped
    cycle(1'b1, OP_MULT, 32'd5, 32'd7, 1'b1);
    idle(2);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_lo", lo, 32'h12345678);

    // flush during busy does not stop commit; start while busy ignored
    cycle(1'b1, OP_MULTU, 32'd6, 32'd7, 1'b0);
    cycle(1'b1, OP_DIV, 32'd1, 32'd1, 1'b1);
    cycle(1'b1, OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0);
    idle(3);
    chk("flushbusy_lo", lo, 32'd42);
    chk("flushbusy_hi", hi, 32'd0);

    // signed overflow divide
    cycle(1'b1, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle(10);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);

    // reset in the middle of a divide
    cycle(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
    idle(2);
    reset_n = 1'b0;
    #1;
    m_hi = 0; m_lo = 0; m_left = 0; p_wr = 0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, OP_MULT, 32'd9, 32'd9, 1'b0);
    idle(5);
    chk("postrst_lo", lo, 32'd81);

    // multiply-accumulate encodings (no-ops unless the feature is built in)
    cycle(1'b1, OP_MTHI, 32'd0, 32'd0, 1'b0);
    cycle(1'b1, OP_MTLO, 32'd10, 32'd0, 1'b0);
    cycle(1'b1, OP_MADD, 32'd2, 32'd3, 1'b0);
    idle(5);
    cycle(1'b1, OP_MSUBU, 32'd4, 32'd1, 1'b0);
    idle(5);

    // random ops
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), pick(), pick(),
            1'($urandom_range(0, 7) == 0));
    end
    idle(DC + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
